// File: rtl/commit_checker_pkg.sv
// Shared types and constants for the commit checker: FSM states, channel ids,
// the architectural zero-register index and the expected-entry payload.
package commit_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic CH_REG = 1'b0;
  localparam logic CH_ST  = 1'b1;

  localparam int unsigned XZR_IDX      = 31;
  localparam int unsigned ENTRY_ADDR_W = 8;
  localparam int unsigned ENTRY_DATA_W = 64;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/checker_fifo.sv
// Synchronous expected-result FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module checker_fifo #(
  parameter int unsigned W     = 72,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic         single,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    full    = (count == PW'(DEPTH));
    empty   = (wr_ptr_q == rd_ptr_q);
    single  = (count == PW'(1));
    head    = mem_q[rd_ptr_q[AW-1:0]];
    do_push = push && !full;
    do_pop  = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/commit_checker.sv
// Commit monitor: compares observed write-backs and stores against per-channel
// expected queues and produces a registered pass/fail verdict.
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TIMEOUT    = 64,
  parameter bit          IGNORE_XZR = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic              exp_chan,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [7:0]        err_count,
  output logic              first_err_chan,
  output logic [7:0]        first_err_idx
);

  localparam int unsigned EW = ADDR_W + DATA_W;
  localparam int unsigned IW = $clog2(TIMEOUT + 1) + 1;

  state_e        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [7:0]    err_q, err_d;
  logic          timeout_q, timeout_d;
  logic          pass_q, pass_d;
  logic          fchan_q, fchan_d;
  logic [7:0]    fidx_q, fidx_d;
  logic [7:0]    wb_idx_q, wb_idx_d;
  logic [7:0]    st_idx_q, st_idx_d;

  logic          reg_full, reg_empty, reg_single;
  logic          st_full, st_empty, st_single;
  logic [EW-1:0] reg_head, st_head;
  logic          push_reg, push_st, pop_reg, pop_st;
  logic          wb_chk, st_chk, wb_err, st_err, active, in_run;
  logic [8:0]    err_sum;

  checker_fifo #(.W(EW), .DEPTH(DEPTH)) u_reg_q (
    .clk(clock), .rst_n(reset_n), .flush(clear), .push(push_reg), .pop(pop_reg),
    .din({exp_addr, exp_data}), .full(reg_full), .empty(reg_empty),
    .single(reg_single), .head(reg_head)
  );

  checker_fifo #(.W(EW), .DEPTH(DEPTH)) u_st_q (
    .clk(clock), .rst_n(reset_n), .flush(clear), .push(push_st), .pop(pop_st),
    .din({exp_addr, exp_data}), .full(st_full), .empty(st_empty),
    .single(st_single), .head(st_head)
  );

  always_comb begin
    exp_ready = (state_q == S_IDLE) && !(exp_chan ? st_full : reg_full);
    push_reg  = exp_valid && exp_ready && (exp_chan == CH_REG) && !clear;
    push_st   = exp_valid && exp_ready && (exp_chan == CH_ST) && !clear;
    active    = (state_q != S_IDLE) && !clear;
    in_run    = (state_q == S_RUN) && !clear;
    // Write-backs to the zero register carry no architectural state.
    wb_chk    = active && wb_valid && !(IGNORE_XZR && (wb_addr == 5'(XZR_IDX)));
    st_chk    = active && st_valid;
    pop_reg   = wb_chk && in_run && !reg_empty;
    pop_st    = st_chk && in_run && !st_empty;
    wb_err    = wb_chk && (!pop_reg || (reg_head != {ADDR_W'(wb_addr), wb_data}));
    st_err    = st_chk && (!pop_st || (st_head != {st_addr, st_data}));
    err_sum   = {1'b0, err_q} + 9'(wb_err) + 9'(st_err);
  end

  always_comb begin
    state_d   = state_q;
    idle_d    = idle_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    fchan_d   = fchan_q;
    fidx_d    = fidx_q;
    wb_idx_d  = wb_idx_q;
    st_idx_d  = st_idx_q;
    if (clear) begin
      state_d   = S_IDLE;
      idle_d    = '0;
      err_d     = '0;
      timeout_d = 1'b0;
      fchan_d   = 1'b0;
      fidx_d    = '0;
      wb_idx_d  = '0;
      st_idx_d  = '0;
    end else begin
      err_d = err_sum[8] ? 8'hFF : err_sum[7:0];
      if (wb_chk) wb_idx_d = wb_idx_q + 8'd1;
      if (st_chk) st_idx_d = st_idx_q + 8'd1;
      // Register channel wins the first-error latch on a simultaneous error.
      if ((err_q == 8'd0) && (wb_err || st_err)) begin
        fchan_d = wb_err ? CH_REG : CH_ST;
        fidx_d  = wb_err ? wb_idx_q : st_idx_q;
      end
      case (state_q)
        S_IDLE: begin
          idle_d = '0;
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          idle_d = (wb_chk || st_chk) ? '0 : idle_q + IW'(1);
          if ((reg_empty || (pop_reg && reg_single)) &&
              (st_empty || (pop_st && st_single))) begin
            state_d = S_DONE;
          end else if (!(wb_chk || st_chk) && (idle_q == IW'(TIMEOUT))) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
    pass_d = (state_d == S_DONE) && (err_d == 8'd0) && !timeout_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idle_q    <= '0;
      err_q     <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      fchan_q   <= 1'b0;
      fidx_q    <= '0;
      wb_idx_q  <= '0;
      st_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
      fchan_q   <= fchan_d;
      fidx_q    <= fidx_d;
      wb_idx_q  <= wb_idx_d;
      st_idx_q  <= st_idx_d;
    end
  end

  always_comb begin
    busy           = (state_q == S_RUN);
    done           = (state_q == S_DONE);
    pass           = pass_q;
    timeout        = timeout_q;
    err_count      = err_q;
    first_err_chan = fchan_q;
    first_err_idx  = fidx_q;
  end

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker with hand-computed expectations.
module tb_commit_checker;
  import commit_checker_pkg::*;

  localparam int unsigned TO = 64;
  localparam int unsigned DP = 16;

  logic        clock = 1'b0;
  logic        reset_n, clear, start;
  logic        exp_valid, exp_ready, exp_chan;
  logic [7:0]  exp_addr;
  logic [63:0] exp_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
  logic        st_valid;
  logic [7:0]  st_addr;
  logic [63:0] st_data;
  logic        busy, done, pass, timeout, first_err_chan;
  logic [7:0]  err_count, first_err_idx;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  commit_checker #(
    .DATA_W(64), .ADDR_W(8), .DEPTH(DP), .TIMEOUT(TO), .IGNORE_XZR(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_chan(exp_chan),
    .exp_addr(exp_addr), .exp_data(exp_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .err_count(err_count), .first_err_chan(first_err_chan),
    .first_err_idx(first_err_idx)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic ch, input entry_t e);
    exp_valid = 1'b1;
    exp_chan  = ch;
    exp_addr  = e.addr;
    exp_data  = e.data;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic ev(input logic wv, input logic [4:0] wa, input logic [63:0] wd,
                    input logic sv, input logic [7:0] sa, input logic [63:0] sd);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    st_valid = sv; st_addr = sa; st_data = sd;
    tick();
    wb_valid = 1'b0;
    st_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; start = 1'b0;
    exp_valid = 1'b0; exp_chan = 1'b0; exp_addr = '0; exp_data = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    st_valid = 1'b0; st_addr = '0; st_data = '0;
    tick(); tick();
    chk("rst_ready", 64'(exp_ready), 64'(1));
    chk("rst_busy",  64'(busy), 64'(0));
    chk("rst_done",  64'(done), 64'(0));
    chk("rst_pass",  64'(pass), 64'(0));
    chk("rst_err",   64'(err_count), 64'(0));
    reset_n = 1'b1;
    tick();

    // Clean run across both channels.
    push(CH_REG, '{addr: 8'd2,  data: 64'd35});
    push(CH_REG, '{addr: 8'd2,  data: 64'd22});
    push(CH_ST,  '{addr: 8'd20, data: 64'd6});
    push(CH_ST,  '{addr: 8'd22, data: 64'd6});
    do_start();
    chk("clean_busy", 64'(busy), 64'(1));
    ev(1'b1, 5'd2, 64'd35, 1'b0, 8'd0, 64'd0);
    ev(1'b0, 5'd0, 64'd0, 1'b1, 8'd20, 64'd6);
    ev(1'b1, 5'd2, 64'd22, 1'b0, 8'd0, 64'd0);
    chk("clean_notdone", 64'(done), 64'(0));
    ev(1'b0, 5'd0, 64'd0, 1'b1, 8'd22, 64'd6);
    chk("clean_done", 64'(done), 64'(1));
    chk("clean_pass", 64'(pass), 64'(1));
    chk("clean_err",  64'(err_count), 64'(0));
    chk("clean_busy_off", 64'(busy), 64'(0));
    ev(1'b1, 5'd2, 64'd1, 1'b0, 8'd0, 64'd0);
    chk("done_late_err",  64'(err_count), 64'(1));
    chk("done_late_pass", 64'(pass), 64'(0));

    // Data mismatch on the register channel.
    do_clear();
    chk("clear_done", 64'(done), 64'(0));
    chk("clear_err",  64'(err_count), 64'(0));
    push(CH_REG, '{addr: 8'd16, data: 64'd20});
    do_start();
    ev(1'b1, 5'd16, 64'd21, 1'b0, 8'd0, 64'd0);
    chk("mm_err",   64'(err_count), 64'(1));
    chk("mm_chan",  64'(first_err_chan), 64'(0));
    chk("mm_idx",   64'(first_err_idx), 64'(0));
    chk("mm_done",  64'(done), 64'(1));
    chk("mm_pass",  64'(pass), 64'(0));

    // XZR drop then simultaneous matching events.
    do_clear();
    push(CH_REG, '{addr: 8'd3,  data: 64'd7});
    push(CH_ST,  '{addr: 8'd21, data: 64'd9});
    do_start();
    ev(1'b1, 5'd31, 64'd5, 1'b0, 8'd0, 64'd0);
    chk("xzr_busy", 64'(busy), 64'(1));
    chk("xzr_err",  64'(err_count), 64'(0));
    ev(1'b1, 5'd3, 64'd7, 1'b1, 8'd21, 64'd9);
    chk("sim_done", 64'(done), 64'(1));
    chk("sim_pass", 64'(pass), 64'(1));

    // Simultaneous mismatches on both channels.
    do_clear();
    push(CH_REG, '{addr: 8'd3,  data: 64'd7});
    push(CH_ST,  '{addr: 8'd21, data: 64'd9});
    do_start();
    ev(1'b1, 5'd3, 64'd8, 1'b1, 8'd21, 64'd10);
    chk("sim2_err",  64'(err_count), 64'(2));
    chk("sim2_chan", 64'(first_err_chan), 64'(0));
    chk("sim2_idx",  64'(first_err_idx), 64'(0));
    chk("sim2_pass", 64'(pass), 64'(0));

    // Timeout after one matching write-back.
    do_clear();
    push(CH_REG, '{addr: 8'd4, data: 64'd40});
    push(CH_REG, '{addr: 8'd5, data: 64'd50});
    do_start();
    ev(1'b1, 5'd4, 64'd40, 1'b0, 8'd0, 64'd0);
    for (int i = 1; i < int'(TO); i++) tick();
    chk("to_early", 64'(done), 64'(0));
    tick();
    chk("to_edge_m1", 64'(done), 64'(0));
    tick();
    chk("to_done",    64'(done), 64'(1));
    chk("to_timeout", 64'(timeout), 64'(1));
    chk("to_pass",    64'(pass), 64'(0));
    chk("to_err",     64'(err_count), 64'(0));

    // Fill the register queue, then reject an extra push.
    do_clear();
    for (int i = 0; i < int'(DP); i++)
      push(CH_REG, '{addr: 8'(i), data: 64'(i * 3 + 1)});
    exp_chan = CH_REG;
    #1;
    chk("full_ready_reg", 64'(exp_ready), 64'(0));
    exp_chan = CH_ST;
    #1;
    chk("full_ready_st", 64'(exp_ready), 64'(1));
    push(CH_REG, '{addr: 8'd30, data: 64'hDEAD});
    do_start();
    for (int i = 0; i < int'(DP); i++)
      ev(1'b1, 5'(i), 64'(i * 3 + 1), 1'b0, 8'd0, 64'd0);
    chk("full_done", 64'(done), 64'(1));
    chk("full_pass", 64'(pass), 64'(1));
    chk("full_err",  64'(err_count), 64'(0));

    // Store with an empty store queue is unexpected.
    do_clear();
    push(CH_REG, '{addr: 8'd1, data: 64'd1});
    do_start();
    ev(1'b0, 5'd0, 64'd0, 1'b1, 8'd5, 64'd5);
    chk("unx_err",  64'(err_count), 64'(1));
    chk("unx_chan", 64'(first_err_chan), 64'(1));
    chk("unx_busy", 64'(busy), 64'(1));
    ev(1'b1, 5'd1, 64'd1, 1'b0, 8'd0, 64'd0);
    chk("unx_done", 64'(done), 64'(1));
    chk("unx_pass", 64'(pass), 64'(0));

    // Reset in the middle of a run with errors.
    do_clear();
    for (int i = 0; i < 4; i++) push(CH_REG, '{addr: 8'd6, data: 64'd60});
    do_start();
    for (int i = 0; i < 3; i++) ev(1'b1, 5'd6, 64'd61, 1'b0, 8'd0, 64'd0);
    chk("mid_err",  64'(err_count), 64'(3));
    chk("mid_busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    exp_chan = CH_REG;
    tick();
    reset_n = 1'b1;
    chk("mrst_ready", 64'(exp_ready), 64'(1));
    chk("mrst_busy",  64'(busy), 64'(0));
    chk("mrst_done",  64'(done), 64'(0));
    chk("mrst_pass",  64'(pass), 64'(0));
    chk("mrst_to",    64'(timeout), 64'(0));
    chk("mrst_err",   64'(err_count), 64'(0));
    chk("mrst_chan",  64'(first_err_chan), 64'(0));
    chk("mrst_idx",   64'(first_err_idx), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
